// File: rtl/qpsk_demod.sv
// Hard-decision QPSK demodulator: symbol FIFO feeding a two-bit serializer with block framing.
// Define QPSK_DEMOD_ERASURE_EN to store per-bit erasure flags and drive erase_out.
module qpsk_demod #(
  parameter int unsigned BLOCK_BITS = 192,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [15:0] ERASE_THR  = 16'h1000
) (
  input  logic        clk_100,
  input  logic        Reset_N,
  input  logic        valid_in,
  output logic        ready_out,
  input  logic [15:0] I_comp,
  input  logic [15:0] Q_comp,
  output logic        valid_out,
  input  logic        ready_in,
  output logic        data_out,
  output logic        last_out,
  output logic        erase_out
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(BLOCK_BITS);
`ifdef QPSK_DEMOD_ERASURE_EN
  localparam int unsigned EntryW = 4;
`else
  localparam int unsigned EntryW = 2;
`endif

  typedef enum logic [1:0] {StEmpty, StBit0, StBit1} state_e;

  // FIFO entry layout: {b0, b1} or {b0, b1, e0, e1}
  logic [EntryW-1:0] wr_entry;
  logic [EntryW-1:0] rd_entry;
  logic              rd_b0, rd_b1, rd_e0, rd_e1;

`ifdef QPSK_DEMOD_ERASURE_EN
  // 0x8000 negates to itself and reads as unsigned 0x8000, so it is never erased
  function automatic logic below_thr(input logic [15:0] x);
    logic [15:0] mag;
    mag = x[15] ? (~x + 16'd1) : x;
    return mag < ERASE_THR;
  endfunction

  assign wr_entry = {I_comp[15], Q_comp[15], below_thr(I_comp), below_thr(Q_comp)};
  assign {rd_b0, rd_b1, rd_e0, rd_e1} = rd_entry;
`else
  logic unused_erase;
  assign unused_erase = ^{ERASE_THR, I_comp[14:0], Q_comp[14:0]};
  assign wr_entry     = {I_comp[15], Q_comp[15]};
  assign {rd_b0, rd_b1} = rd_entry;
  assign rd_e0 = 1'b0;
  assign rd_e1 = 1'b0;
`endif

  // Symbol FIFO; pointers carry one extra wrap bit to tell full from empty
  logic [EntryW-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW:0]     wr_ptr_q, rd_ptr_q;
  logic              full, empty, push, pop;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                     (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign ready_out = Reset_N && !full;
  assign push      = valid_in && ready_out;
  assign rd_entry  = mem_q[rd_ptr_q[PtrW-1:0]];

  always_ff @(posedge clk_100) begin
    if (push) begin
      mem_q[wr_ptr_q[PtrW-1:0]] <= wr_entry;
    end
  end

  always_ff @(posedge clk_100 or negedge Reset_N) begin
    if (!Reset_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + (PtrW + 1)'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + (PtrW + 1)'(1);
      end
    end
  end

  // Serializer: b1 and e1 are parked while b0 is on the output
  state_e          state_q, state_d;
  logic            data_q, data_d;
  logic            b1_q, b1_d;
  logic            era_q, era_d;
  logic            e1_q, e1_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            xfer;
  logic            cnt_at_last;

  assign valid_out   = (state_q != StEmpty);
  assign xfer        = valid_out && ready_in;
  assign cnt_at_last = (cnt_q == CntW'(BLOCK_BITS - 1));

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    b1_d    = b1_q;
    era_d   = era_q;
    e1_d    = e1_q;
    pop     = 1'b0;
    case (state_q)
      StEmpty: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = StBit0;
          data_d  = rd_b0;
          b1_d    = rd_b1;
          era_d   = rd_e0;
          e1_d    = rd_e1;
        end
      end
      StBit0: begin
        if (ready_in) begin
          state_d = StBit1;
          data_d  = b1_q;
          era_d   = e1_q;
        end
      end
      StBit1: begin
        if (ready_in) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = StBit0;
            data_d  = rd_b0;
            b1_d    = rd_b1;
            era_d   = rd_e0;
            e1_d    = rd_e1;
          end else begin
            state_d = StEmpty;
            data_d  = 1'b0;
            era_d   = 1'b0;
          end
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (xfer) begin
      cnt_d = cnt_at_last ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_100 or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q <= StEmpty;
      data_q  <= 1'b0;
      b1_q    <= 1'b0;
      era_q   <= 1'b0;
      e1_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      b1_q    <= b1_d;
      era_q   <= era_d;
      e1_q    <= e1_d;
      cnt_q   <= cnt_d;
    end
  end

  assign data_out  = data_q;
  assign erase_out = era_q;
  assign last_out  = valid_out && cnt_at_last;

endmodule

// File: tb/tb_qpsk_demod.sv
// Scoreboard bench for qpsk_demod: expected {bit, last, erase} queued on accept, checked on transfer.
// Erasure expectations follow QPSK_DEMOD_ERASURE_EN.
module tb_qpsk_demod;

  localparam int BlockBits = 192;
`ifdef QPSK_DEMOD_ERASURE_EN
  localparam bit EraseEn = 1'b1;
`else
  localparam bit EraseEn = 1'b0;
`endif

  logic        clk_100 = 1'b0;
  logic        Reset_N = 1'b1;
  logic        valid_in = 1'b0;
  logic        ready_in = 1'b0;
  logic [15:0] I_comp = '0;
  logic [15:0] Q_comp = '0;
  logic        ready_out, valid_out, data_out, last_out, erase_out;

  int total = 0;
  int bad   = 0;
  logic [2:0] exp_q[$];
  int push_bits = 0;

  always #5 clk_100 = ~clk_100;

  qpsk_demod #(
    .BLOCK_BITS(192),
    .FIFO_DEPTH(4),
    .ERASE_THR (16'h1000)
  ) dut (
    .clk_100  (clk_100),
    .Reset_N  (Reset_N),
    .valid_in (valid_in),
    .ready_out(ready_out),
    .I_comp   (I_comp),
    .Q_comp   (Q_comp),
    .valid_out(valid_out),
    .ready_in (ready_in),
    .data_out (data_out),
    .last_out (last_out),
    .erase_out(erase_out)
  );

  function automatic logic [16:0] mag17(input logic [15:0] x);
    return x[15] ? (17'h10000 - {1'b0, x}) : {1'b0, x};
  endfunction

  // Reference model: queue both bits of an accepted symbol with framing and erasure flags
  function automatic void model_push(input logic [15:0] i, input logic [15:0] q);
    logic [1:0] b;
    logic [1:0] e;
    logic       lst;
    b = {i[15], q[15]};
    e = {EraseEn && (mag17(i) < 17'h01000), EraseEn && (mag17(q) < 17'h01000)};
    for (int k = 0; k < 2; k++) begin
      lst = (push_bits == BlockBits - 1);
      exp_q.push_back({b[1-k], lst, e[1-k]});
      push_bits = lst ? 0 : push_bits + 1;
    end
  endfunction

  task automatic apply_reset();
    valid_in = 1'b0;
    ready_in = 1'b0;
    Reset_N  = 1'b0;
    exp_q.delete();
    push_bits = 0;
    repeat (2) @(posedge clk_100);
    @(negedge clk_100);
    Reset_N = 1'b1;
    @(negedge clk_100);
  endtask

  task automatic test_reset();
    Reset_N = 1'b0;
    repeat (2) @(posedge clk_100);
    @(negedge clk_100);
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid_out); end
    total++; if (data_out !== 1'b0) begin bad++; $display("FAIL reset_data: got %b want 0", data_out); end
    total++; if (last_out !== 1'b0) begin bad++; $display("FAIL reset_last: got %b want 0", last_out); end
    total++; if (erase_out !== 1'b0) begin bad++; $display("FAIL reset_erase: got %b want 0", erase_out); end
    total++; if (ready_out !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", ready_out); end
    Reset_N = 1'b1;
    #1;
    total++; if (ready_out !== 1'b1) begin bad++; $display("FAIL reset_release_ready: got %b want 1", ready_out); end
    @(negedge clk_100);
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_idle_valid: got %b want 0", valid_out); end
  endtask

  task automatic test_decision();
    logic [15:0] ti [4] = '{16'h5A82, 16'h5A82, 16'hA57E, 16'hA57E};
    logic [15:0] tq [4] = '{16'h5A82, 16'hA57E, 16'h5A82, 16'hA57E};
    logic [2:0] got, want;
    logic [7:0] seq = '0;
    int first = -1, last = -1, nvalid = 0;
    ready_in = 1'b1;
    for (int c = 0; c < 14; c++) begin
      if ((c % 2 == 0) && (c < 8)) begin
        valid_in = 1'b1; I_comp = ti[c/2]; Q_comp = tq[c/2];
      end else begin
        valid_in = 1'b0;
      end
      if (valid_out) begin nvalid++; if (first < 0) first = c; last = c; end
      if (valid_out && ready_in) begin
        total++;
        seq = {seq[6:0], data_out};
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL decision_bit: got %b want no transfer", data_out);
        end else begin
          got = {data_out, last_out, erase_out}; want = exp_q.pop_front();
          if (got !== want) begin bad++; $display("FAIL decision_bit: got %b want %b", got, want); end
        end
      end
      if (valid_in && ready_out) model_push(I_comp, Q_comp);
      @(posedge clk_100); @(negedge clk_100);
    end
    total++; if (seq !== 8'b00011011) begin bad++; $display("FAIL decision_seq: got %b want 00011011", seq); end
    total++; if (nvalid != 8) begin bad++; $display("FAIL decision_valid_cycles: got %0d want 8", nvalid); end
    total++; if (first != 2) begin bad++; $display("FAIL decision_latency: got cycle %0d want 2", first); end
    total++; if (last != 9) begin bad++; $display("FAIL decision_contiguous: got last %0d want 9", last); end
  endtask

  task automatic test_boundary();
    logic [15:0] ti [2] = '{16'h0000, 16'h7FFF};
    logic [15:0] tq [2] = '{16'h8000, 16'hFFFF};
    logic [2:0] got, want;
    logic [3:0] seq = '0;
    ready_in = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if ((c % 2 == 0) && (c < 4)) begin
        valid_in = 1'b1; I_comp = ti[c/2]; Q_comp = tq[c/2];
      end else begin
        valid_in = 1'b0;
      end
      if (valid_out && ready_in) begin
        total++;
        seq = {seq[2:0], data_out};
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL boundary_bit: got %b want no transfer", data_out);
        end else begin
          got = {data_out, last_out, erase_out}; want = exp_q.pop_front();
          if (got !== want) begin bad++; $display("FAIL boundary_bit: got %b want %b", got, want); end
        end
      end
      if (valid_in && ready_out) model_push(I_comp, Q_comp);
      @(posedge clk_100); @(negedge clk_100);
    end
    total++; if (seq !== 4'b0101) begin bad++; $display("FAIL boundary_seq: got %b want 0101", seq); end
  endtask

  task automatic test_backpressure();
    logic [2:0] got, want;
    int accepted = 0, drained = 0;
    ready_in = 1'b0;
    for (int c = 0; c < 9; c++) begin
      valid_in = 1'b1;
      if (ready_out) begin
        I_comp = 16'($urandom); Q_comp = 16'($urandom);
      end else begin
        I_comp = 'x; Q_comp = 'x;
      end
      if (valid_out) begin
        total++;
        if (data_out !== exp_q[0][2]) begin
          bad++; $display("FAIL bp_hold: got %b want %b", data_out, exp_q[0][2]);
        end
      end
      if (valid_in && ready_out) begin model_push(I_comp, Q_comp); accepted++; end
      @(posedge clk_100); @(negedge clk_100);
    end
    total++; if (accepted != 5) begin bad++; $display("FAIL bp_accepted: got %0d want 5", accepted); end
    total++; if (ready_out !== 1'b0) begin bad++; $display("FAIL bp_ready: got %b want 0", ready_out); end
    valid_in = 1'b0; I_comp = '0; Q_comp = '0;
    ready_in = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (valid_out && ready_in) begin
        total++; drained++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL bp_drain_bit: got %b want no transfer", data_out);
        end else begin
          got = {data_out, last_out, erase_out}; want = exp_q.pop_front();
          if (got !== want) begin bad++; $display("FAIL bp_drain_bit: got %b want %b", got, want); end
        end
      end
      @(posedge clk_100); @(negedge clk_100);
    end
    total++; if (drained != 10) begin bad++; $display("FAIL bp_drained: got %0d want 10", drained); end
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL bp_empty_after: got %b want 0", valid_out); end
  endtask

  task automatic test_erasure();
    logic [15:0] ti [4] = '{16'h0800, 16'h8000, 16'h1000, 16'hFFFF};
    logic [15:0] tq [4] = '{16'hA57E, 16'hF001, 16'hF000, 16'h0001};
    logic [7:0] exp_era;
    logic [2:0] got, want;
    logic [7:0] dseq = '0;
    logic [7:0] eseq = '0;
    exp_era = EraseEn ? 8'b10010011 : 8'b00000000;
    ready_in = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if ((c % 2 == 0) && (c < 8)) begin
        valid_in = 1'b1; I_comp = ti[c/2]; Q_comp = tq[c/2];
      end else begin
        valid_in = 1'b0;
      end
      if (valid_out && ready_in) begin
        total++;
        dseq = {dseq[6:0], data_out};
        eseq = {eseq[6:0], erase_out};
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL erasure_bit: got %b want no transfer", data_out);
        end else begin
          got = {data_out, last_out, erase_out}; want = exp_q.pop_front();
          if (got !== want) begin bad++; $display("FAIL erasure_bit: got %b want %b", got, want); end
        end
      end
      if (valid_in && ready_out) model_push(I_comp, Q_comp);
      @(posedge clk_100); @(negedge clk_100);
    end
    total++; if (dseq !== 8'b01110110) begin bad++; $display("FAIL erasure_data_seq: got %b want 01110110", dseq); end
    total++; if (eseq !== exp_era) begin bad++; $display("FAIL erasure_flag_seq: got %b want %b", eseq, exp_era); end
  endtask

  task automatic test_framing();
    logic [2:0] got, want;
    int nbit = 0, nlast = 0;
    apply_reset();
    ready_in = 1'b1;
    for (int c = 0; c < 392; c++) begin
      if ((c % 2 == 0) && (c / 2 < 192)) begin
        valid_in = 1'b1; I_comp = 16'($urandom); Q_comp = 16'($urandom);
      end else begin
        valid_in = 1'b0;
      end
      if (valid_out && ready_in) begin
        nbit++;
        if (last_out) begin
          nlast++;
          total++;
          if (nbit % BlockBits != 0) begin bad++; $display("FAIL frame_last_pos: got bit %0d want multiple of 192", nbit); end
        end
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL frame_bit: got %b want no transfer", data_out);
        end else begin
          got = {data_out, last_out, erase_out}; want = exp_q.pop_front();
          if (got !== want) begin bad++; $display("FAIL frame_bit %0d: got %b want %b", nbit, got, want); end
        end
      end
      if (valid_in && ready_out) model_push(I_comp, Q_comp);
      @(posedge clk_100); @(negedge clk_100);
    end
    total++; if (nbit != 384) begin bad++; $display("FAIL frame_bits: got %0d want 384", nbit); end
    total++; if (nlast != 2) begin bad++; $display("FAIL frame_last_count: got %0d want 2", nlast); end
  endtask

  task automatic test_reset_mid();
    logic [2:0] got, want;
    int nbit = 0, nlast = 0, lastpos = -1;
    ready_in = 1'b1;
    for (int c = 0; c < 300 && nbit < 50; c++) begin
      valid_in = (exp_q.size() <= 6);
      I_comp = 16'($urandom); Q_comp = 16'($urandom);
      if (valid_out && ready_in) begin
        nbit++;
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL rmid_bit: got %b want no transfer", data_out);
        end else begin
          got = {data_out, last_out, erase_out}; want = exp_q.pop_front();
          if (got !== want) begin bad++; $display("FAIL rmid_bit %0d: got %b want %b", nbit, got, want); end
        end
      end
      if (valid_in && ready_out) model_push(I_comp, Q_comp);
      @(posedge clk_100); @(negedge clk_100);
    end
    total++; if (nbit != 50) begin bad++; $display("FAIL rmid_reach: got %0d bits want 50", nbit); end
    Reset_N = 1'b0;
    #1;
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL rmid_valid: got %b want 0", valid_out); end
    total++; if (data_out !== 1'b0) begin bad++; $display("FAIL rmid_data: got %b want 0", data_out); end
    total++; if (last_out !== 1'b0) begin bad++; $display("FAIL rmid_last: got %b want 0", last_out); end
    total++; if (erase_out !== 1'b0) begin bad++; $display("FAIL rmid_erase: got %b want 0", erase_out); end
    total++; if (ready_out !== 1'b0) begin bad++; $display("FAIL rmid_ready: got %b want 0", ready_out); end
    valid_in = 1'b0;
    exp_q.delete();
    push_bits = 0;
    repeat (2) @(posedge clk_100);
    @(negedge clk_100);
    Reset_N = 1'b1;
    #1;
    total++; if (ready_out !== 1'b1) begin bad++; $display("FAIL rmid_release_ready: got %b want 1", ready_out); end
    @(negedge clk_100);
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL rmid_flushed: got %b want 0", valid_out); end
    nbit = 0;
    for (int c = 0; c < 200; c++) begin
      if ((c % 2 == 0) && (c / 2 < 96)) begin
        valid_in = 1'b1; I_comp = 16'($urandom); Q_comp = 16'($urandom);
      end else begin
        valid_in = 1'b0;
      end
      if (valid_out && ready_in) begin
        nbit++;
        if (last_out) begin nlast++; lastpos = nbit; end
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL rmid_post_bit: got %b want no transfer", data_out);
        end else begin
          got = {data_out, last_out, erase_out}; want = exp_q.pop_front();
          if (got !== want) begin bad++; $display("FAIL rmid_post_bit %0d: got %b want %b", nbit, got, want); end
        end
      end
      if (valid_in && ready_out) model_push(I_comp, Q_comp);
      @(posedge clk_100); @(negedge clk_100);
    end
    total++; if (nlast != 1) begin bad++; $display("FAIL rmid_last_count: got %0d want 1", nlast); end
    total++; if (lastpos != 192) begin bad++; $display("FAIL rmid_last_pos: got %0d want 192", lastpos); end
  endtask

  initial begin
    test_reset();
    test_decision();
    test_boundary();
    test_backpressure();
    test_erasure();
    test_framing();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/qpsk_demod.md
Name: qpsk_demod

Overview:
- Receive-side counterpart of the team's QPSK modulator.
- Accepts one Q15 I/Q symbol per handshake and makes a hard sign decision on each component.
- Emits the two recovered bits serially, b0 (from I) first, then b1 (from Q), for the deinterleaver.
- Buffers symbols in a small FIFO and flags the last bit of each 192-bit block.

Parameters:
- BLOCK_BITS, 192, bits per block; sets the last_out position. Must be even.
- FIFO_DEPTH, 4, symbol FIFO entries; power of 2, at least 2.
- ERASE_THR, 16'h1000, magnitude threshold for erasure (optional feature only).

Ports:
- clk_100 input 1: 100 MHz clock.
- Reset_N input 1: reset, asynchronous, active-low.
- valid_in input 1: upstream symbol valid.
- ready_out output 1: demod can accept a symbol.
- I_comp input 16: I component, Q15 signed.
- Q_comp input 16: Q component, Q15 signed.
- valid_out output 1: data_out holds a valid bit.
- ready_in input 1: downstream accepts the bit.
- data_out output 1: recovered serial bit.
- last_out output 1: final bit of the current block.
- erase_out output 1: erasure flag for data_out (optional feature; tied 0 when the feature is disabled).

Behaviour:
- Decision: bit = MSB of the component.
  - 0x0000..0x7FFF -> 0; 0x8000..0xFFFF -> 1.
  - b0 = I_comp[15], b1 = Q_comp[15].
  - This inverts the modulator map: 00=(+,+), 01=(+,-), 10=(-,+), 11=(-,-).
- Input handshake:
  - A symbol is accepted on a rising edge where valid_in && ready_out.
  - The decided pair {b0,b1} is written to the FIFO on that edge.
  - ready_out = Reset_N && !fifo_full. It is combinational and has no same-cycle pass-through when full.
- Serializer FSM, registered outputs:
  - EMPTY: valid_out=0. If the FIFO is non-empty, pop, load data_out=b0, go to BIT0.
  - BIT0: valid_out=1, data_out=b0. Hold until ready_in. On ready_in: data_out=b1, go to BIT1.
  - BIT1: valid_out=1, data_out=b1. Hold until ready_in. On ready_in: if the FIFO is non-empty, pop, load b0, go to BIT0; else go to EMPTY.
  - A pop on the BIT1->BIT0 transition gives back-to-back bits with no bubble.
- Output handshake:
  - While valid_out=1 && ready_in=0, data_out, last_out and erase_out stay stable.
  - valid_out never drops without a transfer.
- Latency: a symbol accepted at edge N into an empty FIFO and EMPTY state gives valid_out=1 with b0 after edge N+1.
- Throughput: 1 bit/cycle with ready_in held high, sustained by one symbol every 2 cycles.
- FIFO:
  - Simultaneous push and pop is allowed when not full; the count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Block counter:
  - Width is clog2(BLOCK_BITS). It increments on each output transfer (valid_out && ready_in).
  - last_out = valid_out && (count == BLOCK_BITS-1).
  - It wraps to 0 on the transfer of the last bit.
- Reset, asynchronous and possible mid-operation:
  - FIFO is flushed; FSM goes to EMPTY; block counter goes to 0.
  - valid_out=0, data_out=0, last_out=0, erase_out=0, ready_out=0.
  - After release, ready_out=1 on the first cycle.
- valid_in with X data while ready_out=0 is ignored.

Optional Feature:
- Macro: QPSK_DEMOD_ERASURE_EN.
- Defined:
  - Each FIFO entry also stores e0 = (|I_comp| < ERASE_THR) and e1 = (|Q_comp| < ERASE_THR).
  - Magnitude uses two's-complement negation; 0x8000 is treated as magnitude 0x8000, so it is not erased.
  - erase_out accompanies the matching bit with the same timing and stability rules as data_out.
- Undefined: no erasure storage in the FIFO; erase_out is constant 0.

Test Plan:
- Decision map: with ready_in=1, send symbols (5A82,5A82), (5A82,A57E), (A57E,5A82), (A57E,A57E) on alternate cycles -> data_out sequence 0,0,0,1,1,0,1,1, contiguous, valid_out high for 8 cycles.
- Sign boundaries: I/Q = (0000,8000), then (7FFF,FFFF) -> bits 0,1,0,1.
- Backpressure:
  - ready_in=0, valid_in=1 continuously -> 5 symbols accepted (1 in serializer, 4 in FIFO), then ready_out=0.
  - data_out stays at the first b0.
  - Raising ready_in drains all 10 bits in order over 10 cycles.
- Block framing: stream 96 symbols back-to-back, then 96 more -> last_out high only on bits 192 and 384; the counter is 0 after each.
- Reset mid-block: assert Reset_N=0 after 50 bits with the FIFO holding 2 symbols -> outputs zeroed immediately, FIFO empty; after release, 96 new symbols give last_out on their 192nd bit.
- Erasure (QPSK_DEMOD_ERASURE_EN): symbol (0800,A57E) -> bits 0,1 with erase_out 1,0. Without the macro, erase_out stays 0.
